// File: rtl/mem_master_port_if.sv
// Client request/response and memory-controller bus for mem_master_port.
// master: the port block itself; slave: the client/controller environment.
interface mem_master_port_if;
  // client request
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  // client response
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  // memory controller side
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_di;
  logic       mem_gnt;
  logic [7:0] mem_do;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_gnt, mem_do,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_en, mem_we, mem_addr, mem_di
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_gnt, mem_do,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_en, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/mem_master_port.sv
// Single-outstanding memory master port: accepts one client transaction,
// issues exactly one granted beat to the controller, waits READ_LATENCY
// edges for read data, and returns a one-cycle response. A request that is
// never granted is abandoned after GNT_TIMEOUT ungranted edges (rsp_err=1).
// Every output is a flop or a decode of the state register.
module mem_master_port #(
  parameter int unsigned READ_LATENCY = 2,   // 1..7
  parameter int unsigned GNT_TIMEOUT  = 15   // 1..255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_master_port_if.master  bus
);

  localparam logic [2:0] RL  = 3'(READ_LATENCY);
  localparam logic [7:0] TMO = 8'(GNT_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       we_q,    we_d;      // latched request direction
  logic [7:0] addr_q,  addr_d;    // drives mem_addr, holds between requests
  logic [7:0] di_q,    di_d;      // drives mem_di, holds between requests
  logic [7:0] rdata_q, rdata_d;   // response data
  logic       err_q,   err_d;     // response error (grant timeout)
  logic [7:0] wcnt_q,  wcnt_d;    // ungranted REQ edges so far
  logic [2:0] lat_q,   lat_d;     // edges since the grant edge (reads)

  logic       wcnt_hit;

  // The edge that would bring the wait counter to GNT_TIMEOUT.
  assign wcnt_hit = (wcnt_q + 8'd1) == TMO;

  // Next-state and datapath decode; a grant on the timeout edge wins.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    di_d    = di_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = REQ;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          di_d    = bus.req_wdata;
          rdata_d = 8'h00;
          err_d   = 1'b0;
          wcnt_d  = 8'd0;
          lat_d   = 3'd0;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          err_d   = 1'b0;
          rdata_d = 8'h00;
          if (we_q) begin
            state_d = RESP;
          end else begin
            // grant edge counts as edge 0; capture happens at edge RL
            state_d = WAIT;
            lat_d   = 3'd1;
          end
        end else if (wcnt_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 8'h00;
          wcnt_d  = TMO;
        end else begin
          wcnt_d  = wcnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (lat_q == RL) begin
          state_d = RESP;
          rdata_d = bus.mem_do;
          err_d   = 1'b0;
        end else begin
          lat_d   = lat_q + 3'd1;
        end
      end
      RESP: begin
        // no backpressure: the response is a single-cycle pulse
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      di_q    <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      wcnt_q  <= 8'd0;
      lat_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      lat_q   <= lat_d;
    end
  end

  // Outputs: state decodes plus registered datapath, no input feedthrough.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_en    = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_di    = di_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_master_port.sv
// Bench for mem_master_port: vector table driven through a client driver,
// a memory-controller responder model, and an in-order response scoreboard.
`timescale 1ns/1ps
module tb_mem_master_port;
  localparam int RL  = 2;
  localparam int TMO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_master_port_if bus ();

  mem_master_port #(.READ_LATENCY(RL), .GNT_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         gdly;      // ungranted REQ edges before the grant edge
    logic [7:0] rd;        // data the memory model returns
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         cyc;       // cycle index in which rsp_valid must appear
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   stable_bad = 0;
  int   ready_bad = 0;
  bit   gnt_noise = 0;
  exp_t exp_q[$];
  vec_t cfg_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] a, input logic [7:0] d,
                              input int g, input logic [7:0] rd);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.gdly = g; v.rd = rd;
    v.exp_err   = (g >= TMO);
    v.exp_rdata = (we || v.exp_err) ? 8'h00 : rd;
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 1);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, " rsp_err"},   32'(bus.rsp_err),   0);
    chk({tag, " rsp_rdata"}, 32'(bus.rsp_rdata), 0);
    chk({tag, " mem_en"},    32'(bus.mem_en),    0);
    chk({tag, " mem_we"},    32'(bus.mem_we),    0);
    chk({tag, " mem_addr"},  32'(bus.mem_addr),  0);
    chk({tag, " mem_di"},    32'(bus.mem_di),    0);
  endtask

  // Call at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic issue(input vec_t v);
    int   t;
    exp_t e;
    t = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      chk("handshake timeout", 0, 1);
      return;
    end
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    e.cyc   = cyc + 1 + (v.exp_err ? TMO : v.gdly + 1) + ((!v.we && !v.exp_err) ? RL : 0);
    exp_q.push_back(e);
    cfg_q.push_back(v);
    @(posedge clk); #1;
  endtask

  // Wait until all responses are out and the port is idle again.
  task automatic drain(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.req_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " drained"}, 32'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Memory-controller model: grants after gdly REQ cycles, presents read
  // data only in the cycle before the capture edge (junk otherwise).
  initial begin : responder
    vec_t       c;
    bit         in_req;
    int         req_n;
    int         since;
    logic [16:0] snap;
    in_req = 0; req_n = 0; since = -1; snap = '0;
    c = mk(1'b0, 8'h00, 8'h00, 0, 8'h00);
    bus.mem_gnt = 1'b0;
    bus.mem_do  = 8'hEE;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      bus.mem_do  = 8'hEE;
      if (!rst_n) begin
        in_req = 0;
        since  = -1;
        continue;
      end
      if (since >= 0) begin
        if (since == 0) chk("mem_en drop after grant", 32'(bus.mem_en), 0);
        if (since == RL - 1 && !c.we) bus.mem_do = c.rd;
        since = (since >= RL) ? -1 : since + 1;
      end
      if (bus.mem_en) begin
        if (!in_req) begin
          in_req = 1;
          req_n  = 0;
          if (cfg_q.size() == 0) chk("unexpected mem_en", 1, 0);
          else c = cfg_q.pop_front();
          chk("mem_we", 32'(bus.mem_we),   32'(c.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(c.addr));
          chk("mem_di", 32'(bus.mem_di),   32'(c.wdata));
          snap = {bus.mem_we, bus.mem_addr, bus.mem_di};
        end else if ({bus.mem_we, bus.mem_addr, bus.mem_di} !== snap) begin
          stable_bad++;
        end
        if (req_n == c.gdly) begin
          bus.mem_gnt = 1'b1;
          since = 0;
        end
        req_n++;
      end else begin
        if (gnt_noise) bus.mem_gnt = 1'b1;
        if (in_req) begin
          in_req = 0;
          chk("mem_en cycles", 32'(req_n), 32'((c.gdly < TMO) ? c.gdly + 1 : TMO));
        end
      end
    end
  end

  // Response scoreboard: in-order compare of data, error and timing.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        if (exp_q.size() == 0) chk("spurious rsp_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          chk("rsp cycle", 32'(cyc),           32'(e.cyc));
        end
      end
      if (bus.req_ready && (bus.mem_en || bus.rsp_valid)) ready_bad++;
    end
  end

  initial begin : main
    vec_t tbl[8];
    vec_t bb[4];
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    tbl[0] = mk(1'b1, 8'h10, 8'hA5, 0,   8'h00);  // write, immediate grant
    tbl[1] = mk(1'b0, 8'h22, 8'h00, 3,   8'h5C);  // read, grant after 3
    tbl[2] = mk(1'b0, 8'h33, 8'h11, 255, 8'h77);  // never granted
    tbl[3] = mk(1'b0, 8'h44, 8'h22, 14,  8'h3C);  // grant on 15th edge wins
    tbl[4] = mk(1'b1, 8'h55, 8'h66, 15,  8'h00);  // grant one cycle too late
    tbl[5] = mk(1'b1, 8'hFF, 8'hFF, 1,   8'h00);
    tbl[6] = mk(1'b0, 8'h00, 8'hC3, 0,   8'h81);
    tbl[7] = mk(1'b0, 8'hA0, 8'h5A, 7,   8'hF0);

    bb[0] = mk(1'b1, 8'h01, 8'h10, 0, 8'h00);
    bb[1] = mk(1'b0, 8'h02, 8'h20, 0, 8'hB2);
    bb[2] = mk(1'b0, 8'h03, 8'h30, 2, 8'h5C);
    bb[3] = mk(1'b1, 8'h04, 8'h40, 1, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i]);
      bus.req_valid = 1'b0;
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d mem_addr hold", i), 32'(bus.mem_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d mem_we idle", i), 32'(bus.mem_we), 0);
    end

    // back-to-back with req_valid held high; stray grants outside REQ
    gnt_noise = 1;
    for (int i = 0; i < 4; i++) issue(bb[i]);
    bus.req_valid = 1'b0;
    drain("b2b");
    gnt_noise = 0;

    // reset pulsed while waiting for read data
    issue(mk(1'b0, 8'h99, 8'h77, 0, 8'h12));
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait mem_en", 32'(bus.mem_en), 0);
    chk("wait req_ready", 32'(bus.req_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("async reset");
    exp_q.delete();
    cfg_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(mk(1'b1, 8'h5A, 8'hA5, 2, 8'h00));
    bus.req_valid = 1'b0;
    drain("post reset");

    chk("REQ outputs stable", 32'(stable_bad), 0);
    chk("req_ready only idle", 32'(ready_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
